// File: rtl/handshake_tx.sv
// Four-phase req/ack transmitter: accepts words on a valid/ready port and
// presents them to an asynchronous receiver via req_out/data_out and ack_in.
module handshake_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_req;
    logic [WIDTH-1:0]       r_data;
    logic                   r_err;
    logic                   w_ack_s;
    logic                   w_thresh;

    // ack_in is asynchronous; only the last synchronizer stage feeds the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign w_ack_s  = r_sync[SYNC_STAGES-1];
    assign w_thresh = (TIMEOUT != 0) && (r_cnt == CNT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_req   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= REQ;
                end
                REQ: begin
                    // With the timeout disabled the counter is frozen so it can never wrap.
                    if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= REL;
                    end else if (w_thresh) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= REL;
                    end
                end
                REL: begin
                    if (!w_ack_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign req_out     = r_req;
    assign data_out    = r_data;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_handshake_tx.sv
// Randomized bench for handshake_tx: a receiver model answers req_out with
// chosen ack delays and every transfer is compared against arithmetic timing rules.
module tb_handshake_tx;

    localparam int S = 2;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, ack_in;
    logic [7:0] in_data;
    logic       in_ready, req_out, busy, timeout_err;
    logic [7:0] data_out;

    logic       in_valid0, ack_in0;
    logic [7:0] in_data0;
    logic       in_ready0, req_out0, busy0, timeout_err0;
    logic [7:0] data_out0;

    int n_tests = 0;
    int n_fail  = 0;

    handshake_tx #(.WIDTH(8), .SYNC_STAGES(S), .TIMEOUT(T)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req_out(req_out), .data_out(data_out),
        .ack_in(ack_in), .busy(busy), .timeout_err(timeout_err)
    );

    handshake_tx #(.WIDTH(8), .SYNC_STAGES(S), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .req_out(req_out0), .data_out(data_out0),
        .ack_in(ack_in0), .busy(busy0), .timeout_err(timeout_err0)
    );

    always #5 clk = ~clk;

    // Receiver raises ack d1 cycles after seeing req high, drops it d2 cycles after req falls.
    // Each synchronizer hop adds a cycle, so req stays high d1+S+1 cycles unless the
    // timeout (exactly T cycles) fires first; ack at the threshold cycle still wins.
    function automatic void model(input int d1, input int d2,
                                  output int hi, output int rel, output int err);
        bit to;
        to  = (d1 + S + 1 > T);
        hi  = to ? T : d1 + S + 1;
        err = to ? 1 : 0;
        // After a timeout the REL wait only sees ack if it arrives on the very next cycle.
        rel = (!to || (d1 + S == T)) ? d2 + S + 1 : 1;
    endfunction

    // Drives one word through the receiver model and measures what the DUT did.
    task automatic do_xfer(input logic [7:0] w, input int d1, input int d2, input bit keep,
                           output int t_wait, output int setup_len, output int hi,
                           output int rel, output bit stable, output int errs,
                           output bit err_first_rel);
        bit acc;
        in_valid = 1'b1; in_data = w;
        t_wait = 0; setup_len = 0; hi = 0; rel = 0; stable = 1'b1; errs = 0;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            t_wait++;
        end while (!acc && t_wait < 100);
        if (!keep) in_valid = 1'b0;
        while (!req_out && setup_len < 100) begin
            setup_len++;
            stable = stable && (data_out === w) && (busy === 1'b1) && (in_ready === 1'b0);
            errs += int'(timeout_err);
            @(posedge clk); #1;
        end
        while (req_out && hi < 5000) begin
            hi++;
            if (hi == d1 + 1) ack_in = 1'b1;
            stable = stable && (data_out === w) && (in_ready === 1'b0);
            errs += int'(timeout_err);
            @(posedge clk); #1;
        end
        err_first_rel = timeout_err;
        while (busy && rel < 100) begin
            if (rel == d2) ack_in = 1'b0;
            rel++;
            stable = stable && (data_out === w) && (req_out === 1'b0) && (in_ready === 1'b0);
            errs += int'(timeout_err);
            @(posedge clk); #1;
        end
        ack_in = 1'b0;
    endtask

    task automatic test_reset();
        int hi_cnt;
        rst_n = 1'b0; ack_in = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
        in_valid0 = 1'b0; ack_in0 = 1'b0; in_data0 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({req_out, data_out, in_ready, busy, timeout_err} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: req=%b data=%h rdy=%b busy=%b err=%b, want 0 00 1 0 0",
                     req_out, data_out, in_ready, busy, timeout_err);
        end
        rst_n = 1'b1; ack_in = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({busy, data_out} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL reset_first_accept: busy=%b data=%h, want 1 3c", busy, data_out);
        end
        in_valid = 1'b0;
        hi_cnt = 0;
        repeat (30) begin
            ack_in = req_out;
            if (req_out) hi_cnt++;
            @(posedge clk); #1;
        end
        ack_in = 1'b0;
        n_tests++;
        if (hi_cnt !== S + 1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_followup: req_high=%0d rdy=%b, want %0d 1", hi_cnt, in_ready, S + 1);
        end
    endtask

    task automatic test_single();
        int tw, sl, hi, rel, errs; bit st, efr;
        do_xfer(8'hA5, 0, 0, 1'b0, tw, sl, hi, rel, st, errs, efr);
        n_tests++;
        if (sl !== 1 || st !== 1'b1) begin
            n_fail++;
            $display("FAIL single_setup: setup_cycles=%0d stable=%b, want 1 1", sl, st);
        end
        n_tests++;
        if (1 + hi + rel + 1 !== 8 || errs !== 0) begin
            n_fail++;
            $display("FAIL single_period: hi=%0d rel=%0d errs=%0d, want period 8 errs 0", hi, rel, errs);
        end
        n_tests++;
        if (data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_hold: data_out=%h, want a5", data_out);
        end
    endtask

    task automatic test_back_to_back();
        int tw, sl, hi, rel, errs, extra; bit st, efr;
        logic [7:0] w;
        for (int i = 1; i <= 3; i++) begin
            w = 8'(i);
            do_xfer(w, 0, 0, (i < 3), tw, sl, hi, rel, st, errs, efr);
            n_tests++;
            if (st !== 1'b1 || sl !== 1 || hi !== S + 1 || rel !== S + 1 || (i > 1 && tw !== 1)) begin
                n_fail++;
                $display("FAIL b2b_word%0d: stable=%b setup=%0d hi=%0d rel=%0d wait=%0d, want 1 1 3 3 1",
                         i, st, sl, hi, rel, tw);
            end
        end
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (req_out || busy) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL b2b_no_extra: busy_cycles=%0d, want 0", extra);
        end
    endtask

    task automatic test_random();
        int tw, sl, hi, rel, errs, d1, d2, ehi, erel, eerr; bit st, efr, keep;
        logic [7:0] w;
        for (int i = 0; i < 16; i++) begin
            w  = 8'($urandom);
            d1 = int'($urandom_range(0, T - S - 2));
            d2 = int'($urandom_range(0, 6));
            keep = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            model(d1, d2, ehi, erel, eerr);
            do_xfer(w, d1, d2, keep, tw, sl, hi, rel, st, errs, efr);
            n_tests++;
            if (st !== 1'b1 || sl !== 1) begin
                n_fail++;
                $display("FAIL rand%0d_data: word=%h stable=%b setup=%0d, want stable 1 setup 1", i, w, st, sl);
            end
            n_tests++;
            if (hi !== ehi || rel !== erel || errs !== eerr) begin
                n_fail++;
                $display("FAIL rand%0d_timing d1=%0d d2=%0d: hi=%0d rel=%0d errs=%0d, want %0d %0d %0d",
                         i, d1, d2, hi, rel, errs, ehi, erel, eerr);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int tw, sl, hi, rel, errs, ehi, erel, eerr;
        bit st, efr;
        int d1s [4] = '{1000, 13, 14, 15};
        int d2s [4] = '{0, 2, 4, 0};
        for (int i = 0; i < 4; i++) begin
            model(d1s[i], d2s[i], ehi, erel, eerr);
            do_xfer(8'hC0 + 8'(i), d1s[i], d2s[i], 1'b0, tw, sl, hi, rel, st, errs, efr);
            n_tests++;
            if (hi !== ehi || rel !== erel || errs !== eerr || efr !== (eerr != 0) || st !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_d1_%0d: hi=%0d rel=%0d errs=%0d first=%b st=%b, want %0d %0d %0d %0d 1",
                         d1s[i], hi, rel, errs, efr, st, ehi, erel, eerr, eerr);
            end
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_glitch();
        int bad;
        in_valid = 1'b0;
        ack_in = 1'b1;
        @(posedge clk); #1;
        ack_in = 1'b0;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (!in_ready || busy || req_out || timeout_err) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_glitch: disturbed_cycles=%0d, want 0", bad);
        end
    endtask

    task automatic test_no_timeout_and_async_reset();
        int guard, cnt, errs;
        in_valid0 = 1'b1; in_data0 = 8'h5A; ack_in0 = 1'b0;
        guard = 0;
        while (!req_out0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid0 = 1'b0;
        cnt = 0; errs = 0;
        repeat (1000) begin
            if (req_out0) cnt++;
            errs += int'(timeout_err0);
            @(posedge clk); #1;
        end
        n_tests++;
        if (cnt !== 1000 || errs !== 0 || data_out0 !== 8'h5A) begin
            n_fail++;
            $display("FAIL no_timeout: req_high=%0d errs=%0d data=%h, want 1000 0 5a", cnt, errs, data_out0);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_out0, busy0, in_ready0, data_out0} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL async_reset: req=%b busy=%b rdy=%b data=%h, want 0 0 1 00",
                     req_out0, busy0, in_ready0, data_out0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_timeout();
        test_glitch();
        test_no_timeout_and_async_reset();
        test_single();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
